nb_twos_to_sm_serial: RTL and testbench

//  Bit-serial decoder from n-bit two's complement to sign/magnitude; the inverse of the

---
 rtl/nb_sm_pkg.sv | 13 +
 rtl/nb_twos_to_sm_serial_if.sv | 25 ++
 rtl/nb_serial_negate_bit.sv | 29 ++
 rtl/nb_twos_to_sm_serial.sv | 112 +++++++++++
 tb/tb_nb_twos_to_sm_serial.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/nb_sm_pkg.sv
// Shared types and constants for the bit-serial two's complement to sign/magnitude decoder.
package nb_sm_pkg;

  localparam int NB_N = 5;
  localparam int CW   = $clog2(NB_N);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/nb_twos_to_sm_serial_if.sv
// Operand-in / result-out handshake bundle of the serial sign/magnitude decoder.
interface nb_twos_to_sm_serial_if #(
  parameter int n = 5
);

  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [n-1:0] mag;
  logic         ovf;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, sign, mag, ovf
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, sign, mag, ovf
  );

endinterface

// File: rtl/nb_serial_negate_bit.sv
// One bit of the serial "copy through the first 1, then invert" negation rule.
module nb_serial_negate_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  input  logic sign,
  input  logic clr,
  input  logic en,
  output logic ob
);

  logic r_seen_one;

  // Remembers whether a 1 has already passed through in the current operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (en) begin
      r_seen_one <= r_seen_one | b;
    end else begin
      r_seen_one <= r_seen_one;
    end
  end

  assign ob = sign ? (b ^ r_seen_one) : b;

endmodule

// File: rtl/nb_twos_to_sm_serial.sv
// Bit-serial two's complement to sign/magnitude decoder, LSB first, n cycles per operand.
module nb_twos_to_sm_serial
  import nb_sm_pkg::*;
#(
  parameter int n = NB_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nb_twos_to_sm_serial_if.slave  bus
);

  localparam int             CNTW    = (n > 1) ? $clog2(n) : 1;
  localparam logic [CNTW-1:0] LAST   = CNTW'(n - 1);
  localparam logic [n-1:0]   MAG_MAX = {1'b1, {(n-1){1'b0}}};

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [n-1:0]    r_sreg;
  logic [n-1:0]    r_mag_sr;
  logic            r_sign_op;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_sign;
  logic [n-1:0]    r_mag;
  logic            r_ovf;

  logic            w_accept;
  logic            w_shift;
  logic            w_ob;
  logic [n-1:0]    w_mag_next;

  assign w_accept   = (r_state == IDLE) && bus.in_valid && r_in_ready;
  assign w_shift    = (r_state == SHIFT);
  assign w_mag_next = {w_ob, r_mag_sr[n-1:1]};

  nb_serial_negate_bit u_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (r_sreg[0]),
    .sign  (r_sign_op),
    .clr   (w_accept),
    .en    (w_shift),
    .ob    (w_ob)
  );

  // Control FSM with the shift datapath; results are published only on SHIFT->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sreg      <= '0;
      r_mag_sr    <= '0;
      r_sign_op   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_sreg     <= bus.a;
            r_sign_op  <= bus.a[n-1];
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          r_sreg   <= r_sreg >> 1;
          r_mag_sr <= w_mag_next;
          r_cnt    <= r_cnt + CNTW'(1);
          if (r_cnt == LAST) begin
            r_mag       <= w_mag_next;
            r_sign      <= r_sign_op;
            r_ovf       <= r_sign_op & (w_mag_next == MAG_MAX);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= SHIFT;
          end
        end
        DONE: begin
          // No same-cycle accept: in_ready only comes back once IDLE is reached.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sign      = r_sign;
  assign bus.mag       = r_mag;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nb_twos_to_sm_serial.sv
// Self-checking bench: directed vector table, hand-written corner sequences, exhaustive and random sweep.
module tb_nb_twos_to_sm_serial;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nb_twos_to_sm_serial_if #(.n(N)) bus ();

  nb_twos_to_sm_serial #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] a;
    logic         s;
    logic [N-1:0] m;
    logic         o;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret a as a signed integer, take its absolute value.
  function automatic void model(input logic [N-1:0] av, output logic s,
                                output logic [N-1:0] m, output logic o);
    int v;
    int mi;
    v  = av[N-1] ? (int'(av) - (1 << N)) : int'(av);
    mi = (v < 0) ? -v : v;
    s  = av[N-1];
    m  = N'(mi);
    o  = (mi == (1 << (N - 1)));
  endfunction

  task automatic do_op(input logic [N-1:0] av, input int stall, input logic es,
                       input logic [N-1:0] em, input logic eo);
    int w;
    int lat;
    w = 0;
    bus.a        = av;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    while (!bus.in_ready && w < 50) begin
      step();
      w++;
    end
    chk("accept_timeout", 32'(w < 50), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a        = N'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    chk("sign", 32'(bus.sign), 32'(es));
    chk("mag", 32'(bus.mag), 32'(em));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_mag", 32'(bus.mag), 32'(em));
      chk("stall_sign", 32'(bus.sign), 32'(es));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hold_mag_idle", 32'(bus.mag), 32'(em));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         es;
    logic [N-1:0] em;
    logic         eo;
    int           w;
    int           pulses;

    vecs[0] = '{5'b00110, 1'b0, 5'b00110, 1'b0};
    vecs[1] = '{5'b11010, 1'b1, 5'b00110, 1'b0};
    vecs[2] = '{5'b11111, 1'b1, 5'b00001, 1'b0};
    vecs[3] = '{5'b10000, 1'b1, 5'b10000, 1'b1};
    vecs[4] = '{5'b00000, 1'b0, 5'b00000, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sign", 32'(bus.sign), 32'd0);
    chk("rst_mag", 32'(bus.mag), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, (i == 1) ? 3 : 0, vecs[i].s, vecs[i].m, vecs[i].o);
    end

    // out_ready already high when the result arrives: one-cycle out_valid.
    bus.out_ready = 1'b1;
    bus.a         = 5'b11111;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) begin
        pulses++;
        chk("pulse_mag", 32'(bus.mag), 32'd1);
      end
    end
    chk("pulse_count", 32'(pulses), 32'd1);
    bus.out_ready = 1'b0;

    // Operand offered while busy must be ignored.
    bus.a        = 5'b11010;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.a        = 5'b01111;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      step();
      w++;
    end
    chk("busy_ign_latency", 32'(w), 32'd2);
    chk("busy_ign_sign", 32'(bus.sign), 32'd1);
    chk("busy_ign_mag", 32'(bus.mag), 32'd6);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    chk("busy_ign_no_second", 32'(pulses), 32'd0);
    bus.out_ready = 1'b0;

    // Reset during SHIFT aborts the operation.
    bus.a        = 5'b10101;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_mag", 32'(bus.mag), 32'd0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    chk("abort_no_result", 32'(pulses), 32'd0);
    chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_idle_mag", 32'(bus.mag), 32'd0);

    for (int v = 0; v < 32; v++) begin
      model(N'(v), es, em, eo);
      do_op(N'(v), int'($urandom_range(0, 3)), es, em, eo);
    end
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] rv;
      rv = N'($urandom);
      model(rv, es, em, eo);
      do_op(rv, int'($urandom_range(0, 2)), es, em, eo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
